// File: rtl/cim_tile_resp_if.sv
// cim_tile_resp_if: write, compute-start and result-read signals of the CIM tile
interface cim_tile_resp_if #(
   parameter int XBAR_SIZE      = 16,
   parameter int DATA_SIZE      = 8,
   parameter int BUS_WIDTH      = 16,
   parameter int OUT_ELEMS      = 4,
   parameter int NUM_CHANNELS   = 2,
   parameter int OBUF_DATA_SIZE = 2*DATA_SIZE+$clog2(XBAR_SIZE)
);
   localparam int EPW           = BUS_WIDTH / DATA_SIZE;
   localparam int NUM_ADDR      = XBAR_SIZE / EPW;
   localparam int NUM_ADDR_OBUF = OUT_ELEMS / NUM_CHANNELS;
   localparam int AW            = NUM_ADDR > 1 ? $clog2(NUM_ADDR) : 1;
   localparam int OAW           = NUM_ADDR_OBUF > 1 ? $clog2(NUM_ADDR_OBUF) : 1;
   localparam int RW            = XBAR_SIZE > 1 ? $clog2(XBAR_SIZE) : 1;
   logic                                       i_cim_we;
   logic [AW-1:0]                              i_cim_addr;
   logic [BUS_WIDTH-1:0]                       i_cim_data;
   logic                                       i_cim_start;
   logic                                       o_cim_ready;
   logic [OAW-1:0]                             i_obuf_addr;
   logic [NUM_CHANNELS-1:0][OBUF_DATA_SIZE-1:0] o_obuf_data;
   logic                                       i_w_we;
   logic [RW-1:0]                              i_w_row;
   logic [OUT_ELEMS*DATA_SIZE-1:0]             i_w_data;
   modport slave (
      input  i_cim_we, i_cim_addr, i_cim_data, i_cim_start, i_obuf_addr, i_w_we, i_w_row, i_w_data,
      output o_cim_ready, o_obuf_data
   );
   modport master (
      output i_cim_we, i_cim_addr, i_cim_data, i_cim_start, i_obuf_addr, i_w_we, i_w_row, i_w_data,
      input  o_cim_ready, o_obuf_data
   );
endinterface

// File: rtl/cim_tile_resp.sv
// cim_tile_resp: crossbar MAC tile, one weight row per cycle into signed accumulators; CIM_TILE_RELU_EN clamps committed results at zero
module cim_tile_resp #(
   parameter int XBAR_SIZE      = 16,
   parameter int DATA_SIZE      = 8,
   parameter int BUS_WIDTH      = 16,
   parameter int OUT_ELEMS      = 4,
   parameter int NUM_CHANNELS   = 2,
   parameter int OBUF_DATA_SIZE = 2*DATA_SIZE+$clog2(XBAR_SIZE)
) (
   input logic              clk,
   input logic              rst,
   cim_tile_resp_if.slave   bus
);
   localparam int EPW           = BUS_WIDTH / DATA_SIZE;
   localparam int NUM_ADDR      = XBAR_SIZE / EPW;
   localparam int NUM_ADDR_OBUF = OUT_ELEMS / NUM_CHANNELS;
   localparam int AW            = NUM_ADDR > 1 ? $clog2(NUM_ADDR) : 1;
   localparam int RW            = XBAR_SIZE > 1 ? $clog2(XBAR_SIZE) : 1;
   localparam int OEW           = OUT_ELEMS > 1 ? $clog2(OUT_ELEMS) : 1;

   typedef enum logic {IDLE, COMPUTE} state_t;

   state_t                              state_q, state_d;
   logic [RW-1:0]                       row_q, row_d;
   logic [BUS_WIDTH-1:0]                xbuf_q [NUM_ADDR];
   logic [OUT_ELEMS*DATA_SIZE-1:0]      w_q [XBAR_SIZE];
   logic signed [OBUF_DATA_SIZE-1:0]    acc_q [OUT_ELEMS];
   logic signed [OBUF_DATA_SIZE-1:0]    acc_d [OUT_ELEMS];
   logic signed [OBUF_DATA_SIZE-1:0]    obuf_q [OUT_ELEMS];
   logic signed [OBUF_DATA_SIZE-1:0]    obuf_d [OUT_ELEMS];
   logic [NUM_CHANNELS-1:0][OBUF_DATA_SIZE-1:0] rd_q, rd_d;
   logic signed [DATA_SIZE-1:0]         x_el;
   logic signed [2*DATA_SIZE-1:0]       prod [OUT_ELEMS];
   logic [31:0]                         ridx;
   logic                                idle, last;

   assign idle            = state_q == IDLE;
   assign last            = row_q == RW'(XBAR_SIZE-1);
   assign bus.o_cim_ready = idle;
   assign bus.o_obuf_data = rd_q;

   // next state, row MAC, commit of the final sums and the registered obuf read
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      x_el    = xbuf_q[AW'(32'(row_q) / EPW)][(32'(row_q) % EPW) * DATA_SIZE +: DATA_SIZE];
      for (int j = 0; j < OUT_ELEMS; j++) begin
         prod[j]   = x_el * $signed(w_q[row_q][j*DATA_SIZE +: DATA_SIZE]);
         acc_d[j]  = acc_q[j];
         obuf_d[j] = obuf_q[j];
      end
      if (idle && bus.i_cim_start) begin
         state_d = COMPUTE;
         row_d   = '0;
         for (int j = 0; j < OUT_ELEMS; j++) acc_d[j] = '0;
      end else if (!idle) begin
         row_d = last ? '0 : row_q + RW'(1);
         for (int j = 0; j < OUT_ELEMS; j++) acc_d[j] = acc_q[j] + OBUF_DATA_SIZE'(prod[j]);
         if (last) begin
            state_d = IDLE;
`ifdef CIM_TILE_RELU_EN
            for (int j = 0; j < OUT_ELEMS; j++) obuf_d[j] = acc_d[j][OBUF_DATA_SIZE-1] ? '0 : acc_d[j];
`else
            for (int j = 0; j < OUT_ELEMS; j++) obuf_d[j] = acc_d[j];
`endif
         end
      end
      rd_d = '0;
      ridx = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         ridx     = 32'(bus.i_obuf_addr) * NUM_CHANNELS + c;
         rd_d[c]  = (32'(bus.i_obuf_addr) < NUM_ADDR_OBUF) ? obuf_q[OEW'(ridx)] : '0;
      end
   end

   // FSM state and row counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   // accumulators, result buffer, read register and idle-only buffer writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q <= '0;
         for (int j = 0; j < OUT_ELEMS; j++) begin
            acc_q[j]  <= '0;
            obuf_q[j] <= '0;
         end
         for (int a = 0; a < NUM_ADDR; a++) xbuf_q[a] <= '0;
         for (int r = 0; r < XBAR_SIZE; r++) w_q[r] <= '0;
      end else begin
         rd_q <= rd_d;
         for (int j = 0; j < OUT_ELEMS; j++) begin
            acc_q[j]  <= acc_d[j];
            obuf_q[j] <= obuf_d[j];
         end
         if (idle && bus.i_cim_we && 32'(bus.i_cim_addr) < NUM_ADDR) xbuf_q[bus.i_cim_addr] <= bus.i_cim_data;
         if (idle && bus.i_w_we && 32'(bus.i_w_row) < XBAR_SIZE) w_q[bus.i_w_row] <= bus.i_w_data;
      end
   end
endmodule

// File: tb/tb_cim_tile_resp.sv
// tb_cim_tile_resp: directed scenarios with a scoreboard queue of expected obuf reads
module tb_cim_tile_resp;
   localparam int W = 20;

   typedef struct {
      logic         addr;
      logic [W-1:0] e0;
      logic [W-1:0] e1;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   logic   rd_v = 1'b0;
   logic   rd_v_d = 1'b0;
   exp_t   q[$];
   exp_t   e;
   int     vectors = 0;
   int     miscompares = 0;

   always #5 clk = ~clk;

   cim_tile_resp_if bus ();
   cim_tile_resp dut (.clk(clk), .rst(rst), .bus(bus));

   always @(posedge clk) rd_v_d <= rd_v;

   // monitor: one read result is due on the negedge after each sampled read
   always @(negedge clk) begin
      if (rd_v_d) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL obuf_rd: read with no expected entry, got %h/%h", bus.o_obuf_data[0], bus.o_obuf_data[1]);
         end else begin
            e = q.pop_front();
            if (bus.o_obuf_data[0] !== e.e0 || bus.o_obuf_data[1] !== e.e1) begin
               miscompares++;
               $display("FAIL obuf_rd addr=%0d: got %h/%h want %h/%h", e.addr, bus.o_obuf_data[0], bus.o_obuf_data[1], e.e0, e.e1);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic rd(input logic a, input logic [W-1:0] e0, input logic [W-1:0] e1);
      q.push_back('{a, e0, e1});
      bus.i_obuf_addr = a;
      rd_v = 1'b1;
      @(negedge clk);
      rd_v = 1'b0;
   endtask

   task automatic rd_all(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2, input logic [W-1:0] c3);
      rd(1'b0, c0, c1);
      rd(1'b1, c2, c3);
   endtask

   task automatic fill(input logic [7:0] xe, input logic [7:0] we);
      for (int a = 0; a < 8; a++) begin
         bus.i_cim_we = 1'b1; bus.i_cim_addr = 3'(a); bus.i_cim_data = {2{xe}};
         @(negedge clk);
      end
      bus.i_cim_we = 1'b0;
      for (int r = 0; r < 16; r++) begin
         bus.i_w_we = 1'b1; bus.i_w_row = 4'(r); bus.i_w_data = {4{we}};
         @(negedge clk);
      end
      bus.i_w_we = 1'b0;
   endtask

   // start a compute, optionally poking start/write at compute cycle inj, and time the busy window
   task automatic run(input string name, input int inj);
      int n = 0;
      bus.i_cim_start = 1'b1;
      @(negedge clk);
      bus.i_cim_start = 1'b0; bus.i_cim_we = 1'b0;
      while (bus.o_cim_ready !== 1'b1 && n < 100) begin
         n++;
         if (n == inj) begin
            bus.i_cim_start = 1'b1; bus.i_cim_we = 1'b1; bus.i_cim_addr = 3'd0; bus.i_cim_data = 16'hFFFF;
         end
         @(negedge clk);
         bus.i_cim_start = 1'b0; bus.i_cim_we = 1'b0;
      end
      chk({name, "_ready_low_cycles"}, 64'(n), 64'd16);
   endtask

   initial begin
      bus.i_cim_we = 1'b0; bus.i_cim_addr = '0; bus.i_cim_data = '0; bus.i_cim_start = 1'b0;
      bus.i_obuf_addr = '0; bus.i_w_we = 1'b0; bus.i_w_row = '0; bus.i_w_data = '0;
      @(negedge clk);
      chk("reset_ready", 64'(bus.o_cim_ready), 64'd1);
      chk("reset_obuf_data", 64'(bus.o_obuf_data), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rd_all(20'h0, 20'h0, 20'h0, 20'h0);

      fill(8'h01, 8'h01);
      run("ones", 0);
      rd_all(20'h10, 20'h10, 20'h10, 20'h10);

      fill(8'h01, 8'hFF);
      run("neg", 0);
`ifdef CIM_TILE_RELU_EN
      rd_all(20'h0, 20'h0, 20'h0, 20'h0);
`else
      rd_all(20'hFFFF0, 20'hFFFF0, 20'hFFFF0, 20'hFFFF0);
`endif

      fill(8'h80, 8'h80);
      run("min", 0);
      rd_all(20'h40000, 20'h40000, 20'h40000, 20'h40000);

      run("ignored", 5);
      rd_all(20'h40000, 20'h40000, 20'h40000, 20'h40000);
      run("after_ignored", 0);
      rd_all(20'h40000, 20'h40000, 20'h40000, 20'h40000);

      bus.i_cim_start = 1'b1;
      @(negedge clk);
      bus.i_cim_start = 1'b0;
      repeat (7) @(negedge clk);
      chk("busy_before_abort", 64'(bus.o_cim_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("abort_ready", 64'(bus.o_cim_ready), 64'd1);
      chk("abort_obuf_data", 64'(bus.o_obuf_data), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("after_abort_ready", 64'(bus.o_cim_ready), 64'd1);
      rd_all(20'h0, 20'h0, 20'h0, 20'h0);

      for (int a = 0; a < 8; a++) begin
         bus.i_cim_we = 1'b1; bus.i_cim_addr = 3'(a); bus.i_cim_data = {8'(2*a+1), 8'(2*a)};
         @(negedge clk);
      end
      bus.i_cim_we = 1'b0;
      for (int r = 0; r < 16; r++) begin
         bus.i_w_we = 1'b1; bus.i_w_row = 4'(r); bus.i_w_data = {8'd3, 8'd2, 8'd1, 8'd0};
         @(negedge clk);
      end
      bus.i_w_we = 1'b0;
      run("order", 0);
      rd_all(20'd0, 20'd120, 20'd240, 20'd360);

      bus.i_cim_we = 1'b1; bus.i_cim_addr = 3'd0; bus.i_cim_data = {8'd5, 8'd0};
      run("write_with_start", 0);
      rd_all(20'd0, 20'd124, 20'd248, 20'd372);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cim_tile_resp.md
CIM_TILE_RESP -- requirements
Module: cim_tile_resp

Interface
REQ-001 SHALL have parameter XBAR_SIZE, default 16: crossbar rows, i.e. input elements per compute.
REQ-002 SHALL have parameter DATA_SIZE, default 8: width of input and weight elements, signed two's complement.
REQ-003 SHALL have parameter BUS_WIDTH, default 16: input-bus width; EPW = BUS_WIDTH/DATA_SIZE elements per word.
REQ-004 SHALL have parameter OUT_ELEMS, default 4: crossbar output columns.
REQ-005 SHALL have parameter NUM_CHANNELS, default 2: obuf elements returned per read.
REQ-006 SHALL have parameter OBUF_DATA_SIZE, default 2*DATA_SIZE+$clog2(XBAR_SIZE): result width, signed.
REQ-007 SHALL derive NUM_ADDR = XBAR_SIZE/EPW and NUM_ADDR_OBUF = OUT_ELEMS/NUM_CHANNELS.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-low.
REQ-010 i_cim_we  in  1  write input word.
REQ-011 i_cim_addr  in  $clog2(NUM_ADDR)  input-buffer word address.
REQ-012 i_cim_data  in  BUS_WIDTH  input word; element k at bits [k*DATA_SIZE +: DATA_SIZE] is input row addr*EPW+k.
REQ-013 i_cim_start  in  1  compute request, single-cycle pulse.
REQ-014 o_cim_ready  out  1  high = idle, accepts writes and start.
REQ-015 i_obuf_addr  in  $clog2(NUM_ADDR_OBUF)  output-buffer read address.
REQ-016 o_obuf_data  out  [NUM_CHANNELS-1:0][OBUF_DATA_SIZE-1:0]  channel c = column i_obuf_addr*NUM_CHANNELS+c.
REQ-017 i_w_we  in  1  weight-row write.
REQ-018 i_w_row  in  $clog2(XBAR_SIZE)  weight row index.
REQ-019 i_w_data  in  OUT_ELEMS*DATA_SIZE  weights; column j at bits [j*DATA_SIZE +: DATA_SIZE].

Function
REQ-020 SHALL implement FSM IDLE -> COMPUTE -> IDLE; o_cim_ready = (state==IDLE), registered.
REQ-021 IDLE: i_cim_we writes i_cim_data to input word i_cim_addr on the clock edge; i_w_we likewise writes the weight row.
REQ-022 IDLE with i_cim_start high: SHALL enter COMPUTE, clear all OUT_ELEMS accumulators, zero row counter; o_cim_ready low from next cycle.
REQ-023 Same-cycle i_cim_we and i_cim_start in IDLE: write SHALL commit first and be used by the compute.
REQ-024 COMPUTE: one row per cycle, acc[j] += W[r][j]*X[r] for all j, signed, full OBUF_DATA_SIZE width, no saturation.
REQ-025 After row XBAR_SIZE-1: SHALL write accumulators to obuf and return to IDLE; o_cim_ready low exactly XBAR_SIZE cycles.
REQ-026 COMPUTE: i_cim_start, i_cim_we, i_w_we SHALL be ignored (no state, buffer or weight change).
REQ-027 o_obuf_data SHALL be registered: reflects i_obuf_addr sampled one cycle earlier; reads permitted in any state and return last committed results.
REQ-028 Obuf SHALL update only at COMPUTE completion; intermediate accumulations not visible.
REQ-029 Address ranges are powers of two in defaults; out-of-range addresses for non-power-of-two configs SHALL be ignored (writes) / return 0 (reads).

Reset
REQ-030 rst low SHALL immediately force IDLE, o_cim_ready=1, row counter 0, accumulators 0, obuf 0, o_obuf_data 0.
REQ-031 Input buffer and weight storage SHALL be cleared to 0 at reset.
REQ-032 Reset during COMPUTE SHALL abort it; no partial results reach obuf.

Configuration
REQ-033 Macro CIM_TILE_RELU_EN defined: values committed to obuf SHALL be max(acc,0).
REQ-034 Macro undefined: raw signed accumulator committed; no other behavioural difference.

Verification (defaults)
REQ-035 All weights 1, all inputs 1, start -> ready low 16 cycles, then every column reads 16 (addr 0 and 1, one-cycle latency).
REQ-036 Weights -1, inputs 1 -> columns read 0xFFFF0 (-16) without CIM_TILE_RELU_EN, 0 with it.
REQ-037 Inputs -128, weights -128 -> every column 262144 (0x40000), no overflow.
REQ-038 Start pulse and i_cim_we (addr 0, 0xFFFF) at cycle 5 of COMPUTE -> ignored; ready timing and results match prior scenario; addr 0 unchanged.
REQ-039 rst asserted at COMPUTE cycle 8 -> ready 1 and o_obuf_data 0 same cycle; obuf reads 0 after release.
REQ-040 Column-distinct weights W[r][j]=j, inputs X[r]=r -> column j reads 120*j, checking element ordering on both buses.
